// File: rtl/ddr_pkg.sv
// ddr_pkg: shared constants and types for the DDR frame scheduler.
//   ADDR_WIDTH - app_addr width
//   ADDR_STEP  - app_addr increment per 128-bit beat
//   LEN_WIDTH  - width of the burst length field
//   sched_state_t - scheduler state encoding (IDLE=0, WR_BUSY=1, RD_BUSY=2)
//   grant_t    - which channel owned the engine last
package ddr_pkg;

  localparam int ADDR_WIDTH = 28;
  localparam int ADDR_STEP  = 8;
  localparam int LEN_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } sched_state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_t;

endpackage

// File: rtl/ddr_frame_sched_if.sv
// ddr_frame_sched_if: burst request bus between the scheduler and ddr_burst.
//   *_burst_req    - request, held high until the matching finish is sampled
//   *_burst_len    - beats per burst (constant)
//   *_burst_addr   - burst start address, stable while req is high
//   *_burst_finish - one-cycle completion pulse from ddr_burst
// Handshake: req rises one cycle after the grant decision and stays high
// with len/addr stable; the engine answers with a single-cycle finish, and
// req drops on the following cycle. A finish with no matching req is ignored.
interface ddr_frame_sched_if import ddr_pkg::*; #(
  parameter int AW = ADDR_WIDTH
) ();

  logic                 wr_burst_req;
  logic [LEN_WIDTH-1:0] wr_burst_len;
  logic [AW-1:0]        wr_burst_addr;
  logic                 wr_burst_finish;
  logic                 rd_burst_req;
  logic [LEN_WIDTH-1:0] rd_burst_len;
  logic [AW-1:0]        rd_burst_addr;
  logic                 rd_burst_finish;

  // Scheduler side
  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_finish
  );

  // ddr_burst side
  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_finish
  );

endinterface

// File: rtl/ddr_frame_sched_addr_gen.sv
// frame_addr_gen: per-channel frame address generator.
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_base        - frame base address
//   i_active      - this channel currently owns the burst engine
//   i_advance     - the active burst finished this cycle
//   i_sync        - restart the frame at i_base
//   o_addr        - base + offset (truncating), derived from registered offset
//   o_frame_done  - one-cycle pulse when the last burst of a frame finishes
module frame_addr_gen import ddr_pkg::*; #(
  parameter int AW         = ADDR_WIDTH,
  parameter int STEP       = 512,
  parameter int FRAME_SIZE = 614400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_base,
  input  logic          i_active,
  input  logic          i_advance,
  input  logic          i_sync,
  output logic [AW-1:0] o_addr,
  output logic          o_frame_done
);

  localparam logic [AW-1:0] L_STEP  = AW'(STEP);
  localparam logic [AW-1:0] L_FRAME = AW'(FRAME_SIZE);

  logic [AW-1:0] r_offset;
  logic          r_pending;
  logic          r_frame_done;
  logic [AW-1:0] w_next;

  assign w_next       = r_offset + L_STEP;
  assign o_addr       = i_base + r_offset;
  assign o_frame_done = r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_active) begin
        // The address must not move under a live request, so a sync during
        // the burst is parked until the burst completes.
        if (i_advance) begin
          r_pending <= 1'b0;
          if (i_sync || r_pending) begin
            r_offset <= '0;
          end else if (w_next == L_FRAME) begin
            r_offset     <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_offset <= w_next;
          end
        end else if (i_sync) begin
          r_pending <= 1'b1;
        end
      end else if (i_sync) begin
        r_offset  <= '0;
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr_frame_sched.sv
// ddr_frame_sched: shares one ddr_burst engine between a write channel
// (camera -> DDR) and a read channel (DDR -> display) with round-robin
// grants, fixed-length bursts and per-channel wrapping frame addresses.
//   ui_clk, sys_rst      - clock, asynchronous active-low reset
//   init_calib_complete  - DDR ready; no new grant while low
//   wr_ch_ready          - write FIFO holds a full burst
//   rd_ch_ready          - read FIFO has room for a full burst
//   wr/rd_frame_sync     - restart that channel's frame at its base
//   bus (master)         - burst request bus to ddr_burst
//   wr/rd_frame_done     - pulse when the last burst of a frame finishes
//   busy                 - engine granted to a channel
//   dbg_state            - current scheduler state
module ddr_frame_sched import ddr_pkg::*; #(
  parameter int                    BURST_LEN   = 64,
  parameter int                    FRAME_BEATS = 76800,
  parameter logic [ADDR_WIDTH-1:0] WR_BASE     = '0,
  parameter logic [ADDR_WIDTH-1:0] RD_BASE     = '0
) (
  input  logic                     ui_clk,
  input  logic                     sys_rst,
  input  logic                     init_calib_complete,
  input  logic                     wr_ch_ready,
  input  logic                     rd_ch_ready,
  input  logic                     wr_frame_sync,
  input  logic                     rd_frame_sync,
  ddr_frame_sched_if.master        bus,
  output logic                     wr_frame_done,
  output logic                     rd_frame_done,
  output logic                     busy,
  output sched_state_t             dbg_state
);

  localparam int STEP       = BURST_LEN * ADDR_STEP;
  localparam int FRAME_SIZE = FRAME_BEATS * ADDR_STEP;

  sched_state_t r_state;
  grant_t       r_last;
  logic         r_wr_req;
  logic         r_rd_req;
  logic         r_busy;
  logic         w_wr_active;
  logic         w_rd_active;
  logic         w_wr_adv;
  logic         w_rd_adv;

  // A finish only counts for the channel that currently owns the engine.
  assign w_wr_active = (r_state == WR_BUSY);
  assign w_rd_active = (r_state == RD_BUSY);
  assign w_wr_adv    = w_wr_active && bus.wr_burst_finish;
  assign w_rd_adv    = w_rd_active && bus.rd_burst_finish;

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state  <= IDLE;
      r_last   <= RD;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (init_calib_complete) begin
            // On contention the channel that did not go last wins.
            if (wr_ch_ready && (!rd_ch_ready || r_last == RD)) begin
              r_state  <= WR_BUSY;
              r_wr_req <= 1'b1;
              r_busy   <= 1'b1;
            end else if (rd_ch_ready) begin
              r_state  <= RD_BUSY;
              r_rd_req <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        WR_BUSY: begin
          if (bus.wr_burst_finish) begin
            r_state  <= IDLE;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_last   <= WR;
          end
        end
        RD_BUSY: begin
          if (bus.rd_burst_finish) begin
            r_state  <= IDLE;
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_last   <= RD;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  frame_addr_gen #(.AW(ADDR_WIDTH), .STEP(STEP), .FRAME_SIZE(FRAME_SIZE)) u_wr_addr (
    .clk          (ui_clk),
    .rst_n        (sys_rst),
    .i_base       (WR_BASE),
    .i_active     (w_wr_active),
    .i_advance    (w_wr_adv),
    .i_sync       (wr_frame_sync),
    .o_addr       (bus.wr_burst_addr),
    .o_frame_done (wr_frame_done)
  );

  frame_addr_gen #(.AW(ADDR_WIDTH), .STEP(STEP), .FRAME_SIZE(FRAME_SIZE)) u_rd_addr (
    .clk          (ui_clk),
    .rst_n        (sys_rst),
    .i_base       (RD_BASE),
    .i_active     (w_rd_active),
    .i_advance    (w_rd_adv),
    .i_sync       (rd_frame_sync),
    .o_addr       (bus.rd_burst_addr),
    .o_frame_done (rd_frame_done)
  );

  assign bus.wr_burst_req = r_wr_req;
  assign bus.rd_burst_req = r_rd_req;
  assign bus.wr_burst_len = LEN_WIDTH'(BURST_LEN);
  assign bus.rd_burst_len = LEN_WIDTH'(BURST_LEN);
  assign busy             = r_busy;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_ddr_frame_sched.sv
module tb_ddr_frame_sched;
  import ddr_pkg::*;

  localparam int                    BURST_LEN   = 64;
  localparam int                    FRAME_BEATS = 256;
  localparam logic [ADDR_WIDTH-1:0] WR_BASE     = 28'h0;
  localparam logic [ADDR_WIDTH-1:0] RD_BASE     = 28'h0100000;
  localparam int                    BPF         = FRAME_BEATS / BURST_LEN;
  localparam int                    STEP_BYTES  = BURST_LEN * ADDR_STEP;
  localparam int                    W           = ADDR_WIDTH + 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         sys_rst;
  logic         calib;
  logic         wr_ch_ready, rd_ch_ready;
  logic         wr_frame_sync, rd_frame_sync;
  logic         wr_frame_done, rd_frame_done, busy;
  sched_state_t dbg_state;
  logic         fin_wr, fin_rd, spur_wr, spur_rd;

  ddr_frame_sched_if bus ();

  assign bus.wr_burst_finish = fin_wr | spur_wr;
  assign bus.rd_burst_finish = fin_rd | spur_rd;

  ddr_frame_sched #(
    .BURST_LEN(BURST_LEN), .FRAME_BEATS(FRAME_BEATS),
    .WR_BASE(WR_BASE), .RD_BASE(RD_BASE)
  ) dut (
    .ui_clk              (clk),
    .sys_rst             (sys_rst),
    .init_calib_complete (calib),
    .wr_ch_ready         (wr_ch_ready),
    .rd_ch_ready         (rd_ch_ready),
    .wr_frame_sync       (wr_frame_sync),
    .rd_frame_sync       (rd_frame_sync),
    .bus                 (bus),
    .wr_frame_done       (wr_frame_done),
    .rd_frame_done       (rd_frame_done),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // {channel, start address} per expected grant
  logic         done_q[$];  // channel of each expected frame_done pulse
  int           checks   = 0;
  int           failures = 0;

  // reference model: bursts completed in the current frame, per channel
  int           m_cnt[2];
  bit           m_last;

  // environment knobs
  bit           resp_en  = 1'b1;
  int           resp_dly = 20;
  bit           resp_ch;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any_req();
    return bus.wr_burst_req || bus.rd_burst_req;
  endfunction

  // Expected outcome of one burst, from the scheduling rules.
  // wr/rd: channel readiness; sm: sync on the granted channel mid-burst;
  // so: sync on the other channel mid-burst.
  task automatic model_burst(input bit wr, input bit rd, input bit sm, input bit so,
                             output bit g);
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] a;
    g    = (wr && rd) ? ~m_last : (wr ? 1'b0 : 1'b1);
    base = g ? RD_BASE : WR_BASE;
    a    = base + ADDR_WIDTH'(m_cnt[g] * STEP_BYTES);
    exp_q.push_back({g, a});
    if (so) m_cnt[!g] = 0;
    if (sm) begin
      m_cnt[g] = 0;
    end else begin
      m_cnt[g]++;
      if (m_cnt[g] == BPF) begin
        m_cnt[g] = 0;
        done_q.push_back(g);
      end
    end
    m_last = g;
  endtask

  task automatic model_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_last   = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_req_high();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (any_req()) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_rise_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_req_low();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!any_req()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_drop_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_burst(input bit wr, input bit rd, input bit sm, input bit so, input bit sp);
    bit g;
    model_burst(wr, rd, sm, so, g);
    @(negedge clk);
    wr_ch_ready = wr;
    rd_ch_ready = rd;
    wait_req_high();
    wr_ch_ready = 1'b0;
    rd_ch_ready = 1'b0;
    if (sp) begin
      @(negedge clk);
      if (g) spur_wr = 1'b1; else spur_rd = 1'b1;
      @(negedge clk);
      spur_wr = 1'b0;
      spur_rd = 1'b0;
      chk("spur_busy", 32'(busy), 32'd1);
      chk("spur_req_held", 32'(g ? bus.rd_burst_req : bus.wr_burst_req), 32'd1);
      chk("spur_other_req", 32'(g ? bus.wr_burst_req : bus.rd_burst_req), 32'd0);
    end
    if (sm || so) begin
      @(negedge clk);
      if (sm) begin if (g) rd_frame_sync = 1'b1; else wr_frame_sync = 1'b1; end
      if (so) begin if (g) wr_frame_sync = 1'b1; else rd_frame_sync = 1'b1; end
      @(negedge clk);
      wr_frame_sync = 1'b0;
      rd_frame_sync = 1'b0;
    end
    wait_req_low();
  endtask

  task automatic idle_sync(input bit ch);
    @(negedge clk);
    if (ch) rd_frame_sync = 1'b1; else wr_frame_sync = 1'b1;
    @(negedge clk);
    wr_frame_sync = 1'b0;
    rd_frame_sync = 1'b0;
    m_cnt[ch] = 0;
  endtask

  // ---------------- ddr_burst responder ----------------
  initial begin
    fin_wr = 1'b0;
    fin_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && sys_rst && any_req()) begin
        resp_ch = bus.rd_burst_req;
        repeat (resp_dly - 1) @(negedge clk);
        if (resp_ch) fin_rd = 1'b1; else fin_wr = 1'b1;
        @(negedge clk);
        fin_wr = 1'b0;
        fin_rd = 1'b0;
        for (int k = 0; k < 4; k++) if (any_req()) @(negedge clk);
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic pop_cmp(input bit ch, input logic [ADDR_WIDTH-1:0] addr,
                         input logic [LEN_WIDTH-1:0] len);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_grant actual_ch=%0d addr=0x%0h expected=none", ch, addr);
    end else begin
      e = exp_q.pop_front();
      chk("grant_channel", 32'(ch), 32'(e[W-1]));
      chk("burst_addr", 32'(addr), 32'(e[ADDR_WIDTH-1:0]));
      chk("burst_len", 32'(len), 32'(BURST_LEN));
      chk("busy_with_req", 32'(busy), 32'd1);
    end
  endtask

  task automatic pop_done(input bit ch);
    bit e;
    if (done_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame_done actual_ch=%0d expected=none", ch);
    end else begin
      e = done_q.pop_front();
      chk("frame_done_channel", 32'(ch), 32'(e));
    end
  endtask

  initial begin
    logic prev_w, prev_r;
    prev_w = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        if (bus.wr_burst_req && !prev_w) pop_cmp(1'b0, bus.wr_burst_addr, bus.wr_burst_len);
        if (bus.rd_burst_req && !prev_r) pop_cmp(1'b1, bus.rd_burst_addr, bus.rd_burst_len);
        if (bus.wr_burst_req && bus.rd_burst_req) chk("dual_req", 32'd1, 32'd0);
        if (wr_frame_done) pop_done(1'b0);
        if (rd_frame_done) pop_done(1'b1);
      end
      prev_w = bus.wr_burst_req;
      prev_r = bus.rd_burst_req;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit g;
    bit wr, rd;
    sys_rst       = 1'b0;
    calib         = 1'b0;
    wr_ch_ready   = 1'b0;
    rd_ch_ready   = 1'b0;
    wr_frame_sync = 1'b0;
    rd_frame_sync = 1'b0;
    spur_wr       = 1'b0;
    spur_rd       = 1'b0;
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(bus.wr_burst_req), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_burst_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'({wr_frame_done, rd_frame_done}), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_burst_addr), 32'(WR_BASE));
    chk("rst_rd_addr", 32'(bus.rd_burst_addr), 32'(RD_BASE));
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    sys_rst = 1'b1;

    // calibration low: no grant despite both channels ready
    wr_ch_ready = 1'b1;
    rd_ch_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("nocalib_req", 32'(any_req()), 32'd0);
      chk("nocalib_busy", 32'(busy), 32'd0);
    end
    model_burst(1'b1, 1'b1, 1'b0, 1'b0, g);
    calib = 1'b1;
    @(negedge clk);
    chk("calib_to_wr_req", 32'(bus.wr_burst_req), 32'd1);
    wr_ch_ready = 1'b0;
    rd_ch_ready = 1'b0;
    wait_req_low();

    // both channels ready: grants alternate, fixed 20-cycle service
    for (int i = 0; i < 8; i++) do_burst(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // write-only traffic across a frame wrap
    for (int i = 0; i < 6; i++) do_burst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // sync during the second write burst of a frame
    resp_dly = 10;
    for (int i = 0; i < BPF && m_cnt[0] != 1; i++) do_burst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_burst(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_burst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // spurious read finish while writing
    do_burst(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_burst(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // calibration drops mid-burst: burst completes, then no grants
    model_burst(1'b1, 1'b0, 1'b0, 1'b0, g);
    @(negedge clk);
    wr_ch_ready = 1'b1;
    wait_req_high();
    calib = 1'b0;
    wait_req_low();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("calib_low_no_grant", 32'(any_req()), 32'd0);
    end
    model_burst(1'b1, 1'b0, 1'b0, 1'b0, g);
    calib = 1'b1;
    wait_req_high();
    wr_ch_ready = 1'b0;
    wait_req_low();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) wr = 1'b1;
      resp_dly = $urandom_range(6, 15);
      do_burst(wr, rd, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 4) == 0) idle_sync(1'($urandom_range(0, 1)));
    end

    // reset in the middle of a write burst
    while (m_cnt[0] == 0) do_burst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    resp_en = 1'b0;
    model_burst(1'b1, 1'b0, 1'b0, 1'b0, g);
    @(negedge clk);
    wr_ch_ready = 1'b1;
    wait_req_high();
    wr_ch_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 sys_rst = 1'b0;
    #1;
    chk("midrst_wr_req", 32'(bus.wr_burst_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_addr", 32'(bus.wr_burst_addr), 32'(WR_BASE));
    chk("midrst_rd_addr", 32'(bus.rd_burst_addr), 32'(RD_BASE));
    model_reset();
    done_q.delete();
    repeat (2) @(negedge clk);
    sys_rst  = 1'b1;
    resp_en  = 1'b1;
    resp_dly = 8;
    for (int i = 0; i < 5; i++) do_burst(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
